// File: rtl/spi_burst_memory.sv
// SPI mode-0 slave in front of an internal synchronous RAM. One frame carries
// ADDR_WIDTH address bits and an R/W bit, then any number of auto-incrementing data words.
module spi_burst_memory #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk_pin,
  input  logic       cs_pin,
  input  logic       mosi_pin,
  output logic       miso_pin,
  output logic [3:0] leds
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int SHW   = (DATA_WIDTH > ADDR_WIDTH + 1) ? DATA_WIDTH : ADDR_WIDTH + 1;
  localparam int CW    = $clog2(SHW + 1);

  localparam logic [2:0] WAIT_CS_HIGH = 3'd0;
  localparam logic [2:0] IDLE         = 3'd1;
  localparam logic [2:0] CMD          = 3'd2;
  localparam logic [2:0] RD_LOAD      = 3'd3;
  localparam logic [2:0] RD_SHIFT     = 3'd4;
  localparam logic [2:0] WR_DATA      = 3'd5;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_hist;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   sclk_fall;

  logic [2:0]             state;
  logic [CW-1:0]          cnt;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [SHW-1:0]         shift;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   word_done;
  logic                   wr_pending;
  logic                   load_pending;
  logic                   miso_q;
  logic                   miso_en;

  // Synchronise the asynchronous SPI pins and keep one history flop for sclk edges
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= {SYNC_STAGES{1'b0}};
      cs_sync   <= {SYNC_STAGES{1'b0}};
      mosi_sync <= {SYNC_STAGES{1'b0}};
      sclk_hist <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_pin};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_pin};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_pin};
      sclk_hist <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign sclk_fall = ~sclk_s & sclk_hist;

  // RAM: a completed write word lands one clk after its last bit; read is registered
  always_ff @(posedge clk) begin
    if (wr_pending && !reset) begin
      mem[addr] <= shift[DATA_WIDTH-1:0];
    end
    rd_data <= mem[addr];
  end

  // Frame sequencer; a synced cs high always wins over a same-clk sclk edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= WAIT_CS_HIGH;
      cnt          <= {CW{1'b0}};
      addr         <= {ADDR_WIDTH{1'b0}};
      shift        <= {SHW{1'b0}};
      word_done    <= 1'b0;
      wr_pending   <= 1'b0;
      load_pending <= 1'b0;
      miso_q       <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (sclk_fall) begin
        miso_q <= shift[DATA_WIDTH-1];
      end
      if (wr_pending) begin
        wr_pending <= 1'b0;
        addr       <= addr + ADDR_WIDTH'(1);
        word_done  <= 1'b1;
      end
      case (state)
        WAIT_CS_HIGH: begin
          if (cs_s) state <= IDLE;
        end
        IDLE: begin
          if (!cs_s) begin
            state <= CMD;
            cnt   <= {CW{1'b0}};
          end
        end
        CMD: begin
          if (cs_s) begin
            state <= IDLE;
          end else if (sclk_rise) begin
            shift <= {shift[SHW-2:0], mosi_s};
            if (cnt == CW'(ADDR_WIDTH)) begin
              addr  <= shift[ADDR_WIDTH-1:0];
              cnt   <= {CW{1'b0}};
              state <= mosi_s ? RD_LOAD : WR_DATA;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        RD_LOAD: begin
          if (cs_s) begin
            state <= IDLE;
          end else begin
            state        <= RD_SHIFT;
            load_pending <= 1'b1;
          end
        end
        RD_SHIFT: begin
          if (cs_s) begin
            state        <= IDLE;
            load_pending <= 1'b0;
          end else if (load_pending) begin
            shift        <= SHW'(rd_data);
            load_pending <= 1'b0;
          end else if (sclk_rise) begin
            shift <= {shift[SHW-2:0], 1'b0};
            if (cnt == CW'(DATA_WIDTH - 1)) begin
              cnt       <= {CW{1'b0}};
              addr      <= addr + ADDR_WIDTH'(1);
              word_done <= 1'b1;
              state     <= RD_LOAD;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        WR_DATA: begin
          if (cs_s) begin
            state <= IDLE;
          end else if (sclk_rise) begin
            shift <= {shift[SHW-2:0], mosi_s};
            if (cnt == CW'(DATA_WIDTH - 1)) begin
              cnt        <= {CW{1'b0}};
              wr_pending <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= WAIT_CS_HIGH;
      endcase
    end
  end

  assign miso_en  = ((state == RD_LOAD) || (state == RD_SHIFT)) && !cs_s;
  assign miso_pin = miso_en ? miso_q : 1'bz;
  assign leds     = {state, word_done};
endmodule

// File: tb/tb_spi_burst_memory.sv
// Bench for spi_burst_memory: an 8/7 instance and a 16/4 instance share sclk/mosi,
// each with its own chip select; reads are checked against a word-level memory model.
module tb_spi_burst_memory;
  logic       clk = 1'b0;
  logic       reset;
  logic       sclk;
  logic       cs_a;
  logic       cs_b;
  logic       mosi;
  wire        miso_a;
  wire        miso_b;
  logic [3:0] leds_a;
  logic [3:0] leds_b;

  int vectors     = 0;
  int miscompares = 0;
  int wd_a        = 0;
  int wd_b        = 0;
  int hp          = 6;

  // Undriven miso floats high, so a released pin reads as 1
  pullup (miso_a);
  pullup (miso_b);

  spi_burst_memory dut_a (
    .clk(clk), .reset(reset), .sclk_pin(sclk), .cs_pin(cs_a),
    .mosi_pin(mosi), .miso_pin(miso_a), .leds(leds_a)
  );

  spi_burst_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .sclk_pin(sclk), .cs_pin(cs_b),
    .mosi_pin(mosi), .miso_pin(miso_b), .leds(leds_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (leds_a[0]) wd_a <= wd_a + 1;
    if (leds_b[0]) wd_b <= wd_b + 1;
  end

  typedef struct {
    bit              sel;
    bit              rd;
    logic [15:0]     addr;
    int              n;
    logic [2:0][15:0] w;
    bit   [2:0]      chk;
    int              hp;
  } vec_t;

  vec_t       tbl [10];
  logic [7:0] model_a [128];
  bit         valid_a [128];

  function automatic vec_t mkv(input bit sel, input bit rd, input logic [15:0] addr,
                               input int n, input logic [15:0] w0, input logic [15:0] w1,
                               input logic [15:0] w2, input int h);
    vec_t v;
    v.sel = sel; v.rd = rd; v.addr = addr; v.n = n;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
    v.chk = 3'b111; v.hp = h;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One SPI bit: mosi set in the low phase, miso sampled just before the rising edge
  task automatic spi_bit(input bit sel, input logic b, input bit glitch, output logic so);
    mosi = b;
    wait_clks(hp);
    so   = sel ? miso_b : miso_a;
    sclk = 1'b1;
    if (glitch) begin
      wait_clks(2);
      #5 mosi = ~b;
      #6 mosi = b;
      wait_clks(hp - 2);
    end else begin
      wait_clks(hp);
    end
    sclk = 1'b0;
  endtask

  task automatic frame_begin(input bit sel, input int aw, input logic [15:0] addr, input bit rd);
    logic so;
    if (sel) cs_b = 1'b0;
    else     cs_a = 1'b0;
    wait_clks(hp);
    for (int i = aw - 1; i >= 0; i--) spi_bit(sel, addr[i], 1'b0, so);
    spi_bit(sel, rd, 1'b0, so);
  endtask

  task automatic frame_end();
    wait_clks(hp);
    cs_a = 1'b1;
    cs_b = 1'b1;
    wait_clks(hp + 4);
  endtask

  task automatic xfer_word(input bit sel, input int dw, input logic [15:0] wd, input bit glitch,
                           output logic [15:0] rdw);
    logic so;
    rdw = 16'h0000;
    for (int i = dw - 1; i >= 0; i--) begin
      spi_bit(sel, wd[i], glitch, so);
      rdw[i] = so;
    end
  endtask

  task automatic run_vec(input vec_t v, input int id, input bit glitch);
    logic [15:0] r;
    int aw, dw, wd0, wd1, a;
    hp  = v.hp;
    aw  = v.sel ? 4 : 7;
    dw  = v.sel ? 16 : 8;
    wd0 = v.sel ? wd_b : wd_a;
    frame_begin(v.sel, aw, v.addr, v.rd);
    check($sformatf("v%0d_state", id), v.sel ? leds_b[3:1] : leds_a[3:1], v.rd ? 32'd4 : 32'd5);
    for (int j = 0; j < v.n; j++) begin
      xfer_word(v.sel, dw, v.rd ? 16'h0000 : v.w[j], glitch, r);
      if (v.rd && v.chk[j]) check($sformatf("v%0d_word%0d", id, j), r, v.w[j]);
    end
    frame_end();
    wd1 = v.sel ? wd_b : wd_a;
    check($sformatf("v%0d_word_done", id), wd1 - wd0, v.n);
    if (!v.rd && !v.sel) begin
      for (int j = 0; j < v.n; j++) begin
        a = (int'(v.addr) + j) % 128;
        model_a[a] = v.w[j][7:0];
        valid_a[a] = 1'b1;
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0]  pat;
    logic [15:0] last_wa;
    logic        so;
    int          found;
    vec_t        v;

    reset = 1'b1; sclk = 1'b0; cs_a = 1'b1; cs_b = 1'b1; mosi = 1'b0;
    for (int i = 0; i < 128; i++) valid_a[i] = 1'b0;

    tbl[0] = mkv(1'b0, 1'b1, 16'h05, 1, 16'h00A5, 16'h0, 16'h0, 6);
    tbl[1] = mkv(1'b0, 1'b0, 16'h7E, 3, 16'h0011, 16'h0022, 16'h0033, 6);
    tbl[2] = mkv(1'b0, 1'b1, 16'h7E, 3, 16'h0011, 16'h0022, 16'h0033, 6);
    tbl[3] = mkv(1'b0, 1'b1, 16'h00, 1, 16'h0033, 16'h0, 16'h0, 6);
    tbl[4] = mkv(1'b1, 1'b0, 16'h0F, 2, 16'hBEEF, 16'h1234, 16'h0, 6);
    tbl[5] = mkv(1'b1, 1'b1, 16'h0F, 2, 16'hBEEF, 16'h1234, 16'h0, 6);
    tbl[6] = mkv(1'b1, 1'b1, 16'h00, 1, 16'h1234, 16'h0, 16'h0, 6);
    tbl[7] = mkv(1'b0, 1'b0, 16'h40, 2, 16'h00C3, 16'h003C, 16'h0, 5);
    tbl[8] = mkv(1'b0, 1'b1, 16'h40, 2, 16'h00C3, 16'h003C, 16'h0, 5);
    tbl[9] = mkv(1'b0, 1'b1, 16'h7F, 2, 16'h0022, 16'h0033, 16'h0, 5);

    wait_clks(5);
    check("reset_leds_a", leds_a, 32'h0);
    check("reset_leds_b", leds_b, 32'h0);
    check("reset_miso_a_z", miso_a, 32'h1);
    reset = 1'b0;
    wait_clks(8);
    check("idle_after_cs_high", leds_a[3:1], 32'd1);

    // Single write then bit-by-bit read of 0xA5
    run_vec(mkv(1'b0, 1'b0, 16'h05, 1, 16'h00A5, 16'h0, 16'h0, 6), 0, 1'b0);
    check("pre_cs_miso_z", miso_a, 32'h1);
    frame_begin(1'b0, 7, 16'h05, 1'b1);
    pat = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(1'b0, 1'b0, 1'b0, so);
      check($sformatf("a5_bit%0d", i), so, pat[i]);
    end
    frame_end();
    check("post_cs_miso_z", miso_a, 32'h1);

    for (int i = 0; i < 10; i++) run_vec(tbl[i], 10 + i, 1'b0);

    // Aborted write leaves the stored word intact
    run_vec(mkv(1'b0, 1'b0, 16'h10, 1, 16'h005A, 16'h0, 16'h0, 6), 30, 1'b0);
    frame_begin(1'b0, 7, 16'h10, 1'b0);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, 1'b1, 1'b0, so);
    cs_a  = 1'b1;
    found = 0;
    for (int k = 1; k <= 4; k++) begin
      wait_clks(1);
      if (found == 0 && leds_a[3:1] == 3'd1) found = k;
    end
    check("abort_idle_in_time", (found != 0) ? 32'd1 : 32'd0, 32'd1);
    wait_clks(hp + 4);
    run_vec(mkv(1'b0, 1'b1, 16'h10, 1, 16'h005A, 16'h0, 16'h0, 6), 31, 1'b0);

    // Reset during WR_DATA bit 6; cs must cycle before a new frame is accepted
    run_vec(mkv(1'b0, 1'b0, 16'h20, 1, 16'h0099, 16'h0, 16'h0, 6), 40, 1'b0);
    frame_begin(1'b0, 7, 16'h20, 1'b0);
    for (int i = 0; i < 6; i++) spi_bit(1'b0, 1'b0, 1'b0, so);
    mosi = 1'b1;
    wait_clks(2);
    reset = 1'b1;
    wait_clks(1);
    check("midreset_leds", leds_a, 32'h0);
    check("midreset_miso_z", miso_a, 32'h1);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) spi_bit(1'b0, 1'b1, 1'b0, so);
    check("midreset_stays_wait", leds_a[3:1], 32'd0);
    frame_end();
    check("midreset_idle_after_cs", leds_a[3:1], 32'd1);
    run_vec(mkv(1'b0, 1'b1, 16'h20, 1, 16'h0099, 16'h0, 16'h0, 6), 41, 1'b0);
    run_vec(mkv(1'b0, 1'b0, 16'h20, 1, 16'h0077, 16'h0, 16'h0, 6), 42, 1'b0);
    run_vec(mkv(1'b0, 1'b1, 16'h20, 1, 16'h0077, 16'h0, 16'h0, 6), 43, 1'b0);

    // mosi glitches inside the high phase must not corrupt the word
    run_vec(mkv(1'b0, 1'b0, 16'h30, 2, 16'h0096, 16'h0069, 16'h0, 6), 50, 1'b1);
    run_vec(mkv(1'b0, 1'b1, 16'h30, 2, 16'h0096, 16'h0069, 16'h0, 6), 51, 1'b0);

    // Random bursts against the word-level model
    last_wa = 16'h7E;
    for (int k = 0; k < 16; k++) begin
      v.sel = 1'b0;
      v.rd  = 1'($urandom_range(0, 1));
      v.n   = $urandom_range(1, 3);
      v.hp  = $urandom_range(5, 8);
      v.chk = 3'b000;
      v.w   = '{16'h0, 16'h0, 16'h0};
      if (v.rd) begin
        v.addr = last_wa;
        for (int j = 0; j < v.n; j++) begin
          v.w[j]   = {8'h00, model_a[(int'(last_wa) + j) % 128]};
          v.chk[j] = valid_a[(int'(last_wa) + j) % 128];
        end
      end else begin
        v.addr  = 16'($urandom_range(0, 127));
        last_wa = v.addr;
        for (int j = 0; j < v.n; j++) v.w[j] = 16'($urandom_range(0, 255));
      end
      run_vec(v, 100 + k, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
